// File: rtl/rsg_param_seq_gen_if.sv
// Bundle between the game controller (master) and the sequence generator (slave).
// Optional replay strobe is present only when RSG_REPLAY_EN is defined.
interface rsg_param_seq_gen_if #(
  parameter int DW      = 4,
  parameter int MAX_LEN = 7,
  parameter int LW      = 3
);
  // Handshake: start, tick and replay are one-cycle strobes sampled on the rising
  // clock edge; flash_digit/flash_idx carry data only while flash_valid is high;
  // done is a one-cycle strobe issued in the same cycle busy falls.
  logic                  start;
  logic                  auth;
  logic [LW-1:0]         level;
  logic                  tick;
`ifdef RSG_REPLAY_EN
  logic                  replay;
`endif
  logic [DW-1:0]         flash_digit;
  logic                  flash_valid;
  logic [LW-1:0]         flash_idx;
  logic [MAX_LEN*DW-1:0] seq_store;
  logic [LW-1:0]         seq_len;
  logic                  busy;
  logic                  done;
  logic [1:0]            state_dbg;

  modport master (
    output start,
    output auth,
    output level,
    output tick,
`ifdef RSG_REPLAY_EN
    output replay,
`endif
    input  flash_digit,
    input  flash_valid,
    input  flash_idx,
    input  seq_store,
    input  seq_len,
    input  busy,
    input  done,
    input  state_dbg
  );

  modport slave (
    input  start,
    input  auth,
    input  level,
    input  tick,
`ifdef RSG_REPLAY_EN
    input  replay,
`endif
    output flash_digit,
    output flash_valid,
    output flash_idx,
    output seq_store,
    output seq_len,
    output busy,
    output done,
    output state_dbg
  );
endinterface

// File: rtl/rsg_param_seq_gen.sv
// Memory-game sequence generator: LFSR digits with no adjacent repeats, flashed per tick.
// Optional feature macro: RSG_REPLAY_EN (redisplay stored sequence without regenerating).
module rsg_param_seq_gen #(
  parameter int          DW      = 4,
  parameter int          MAX_LEN = 7,
  parameter int          LW      = 3,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               clock,
  input  logic               rst,
  rsg_param_seq_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GEN  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [15:0]           lfsr;
  logic [LW-1:0]         wr_idx;
  logic [DW-1:0]         prev_digit;
  logic [DW-1:0]         raw_digit;
  logic [DW-1:0]         gen_digit;
  logic [DW-1:0]         load_digit;
  logic [DW-1:0]         next_digit;
  logic [LW-1:0]         len_clamped;
  logic [LW-1:0]         last_idx;

  logic [DW-1:0]         flash_digit;
  logic                  flash_valid;
  logic [LW-1:0]         flash_idx;
  logic [MAX_LEN*DW-1:0] seq_store;
  logic [LW-1:0]         seq_len;
  logic                  done;

  logic ld_len, arm_go, wr_en, show_load, show_adv, show_end;

  assign raw_digit = lfsr[DW-1:0];
  assign last_idx  = seq_len - LW'(1);

  // A raw digit equal to its predecessor is bumped by one so neighbours always differ.
  assign gen_digit = ((wr_idx != '0) && (raw_digit == prev_digit))
                   ? raw_digit + DW'(1) : raw_digit;

  // On a one-digit round slot 0 is written on the same edge SHOW is entered.
  assign load_digit = ((state == S_GEN) && (wr_idx == '0))
                    ? gen_digit : seq_store[DW-1:0];

  always_comb begin
    len_clamped = bus.level;
    if (bus.level == '0)
      len_clamped = LW'(1);
    else if (bus.level > LW'(MAX_LEN))
      len_clamped = LW'(MAX_LEN);
  end

  always_comb begin
    next_digit = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (flash_idx + LW'(1) == LW'(i))
        next_digit = seq_store[i*DW +: DW];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_len     = 1'b0;
    arm_go     = 1'b0;
    wr_en      = 1'b0;
    show_load  = 1'b0;
    show_adv   = 1'b0;
    show_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_ARM;
          ld_len     = 1'b1;
        end
`ifdef RSG_REPLAY_EN
        else if (bus.replay && (seq_len != '0)) begin
          state_next = S_SHOW;
          show_load  = 1'b1;
        end
`endif
      end
      S_ARM: begin
        if (bus.auth) begin
          state_next = S_GEN;
          arm_go     = 1'b1;
        end
      end
      S_GEN: begin
        wr_en = 1'b1;
        if (wr_idx == last_idx) begin
          state_next = S_SHOW;
          show_load  = 1'b1;
        end
      end
      S_SHOW: begin
        if (bus.tick) begin
          if (flash_idx == last_idx) begin
            state_next = S_IDLE;
            show_end   = 1'b1;
          end else begin
            show_adv = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lfsr        <= SEED;
      wr_idx      <= '0;
      prev_digit  <= '0;
      seq_store   <= '0;
      seq_len     <= '0;
      flash_digit <= '0;
      flash_valid <= 1'b0;
      flash_idx   <= '0;
      done        <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      done <= show_end;
      if (ld_len)
        seq_len <= len_clamped;
      if (arm_go) begin
        seq_store <= '0;
        wr_idx    <= '0;
      end
      if (wr_en) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (wr_idx == LW'(i))
            seq_store[i*DW +: DW] <= gen_digit;
        end
        prev_digit <= gen_digit;
        wr_idx     <= wr_idx + LW'(1);
      end
      if (show_load) begin
        flash_valid <= 1'b1;
        flash_idx   <= '0;
        flash_digit <= load_digit;
      end
      if (show_adv) begin
        flash_idx   <= flash_idx + LW'(1);
        flash_digit <= next_digit;
      end
      if (show_end) begin
        flash_valid <= 1'b0;
        flash_idx   <= '0;
        flash_digit <= '0;
      end
    end
  end

  assign bus.flash_digit = flash_digit;
  assign bus.flash_valid = flash_valid;
  assign bus.flash_idx   = flash_idx;
  assign bus.seq_store   = seq_store;
  assign bus.seq_len     = seq_len;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done;
  assign bus.state_dbg   = state;

  a_done_not_busy: assert property (@(posedge clock) disable iff (rst)
    bus.done |-> !bus.busy);
  a_valid_in_show: assert property (@(posedge clock) disable iff (rst)
    bus.flash_valid == (state == S_SHOW));

endmodule

// File: tb/tb_rsg_param_seq_gen.sv
// Randomised scoreboard bench for rsg_param_seq_gen against an edge-counted LFSR model.
module tb_rsg_param_seq_gen;
  localparam int          DW      = 4;
  localparam int          MAX_LEN = 7;
  localparam int          LW      = 3;
  localparam logic [15:0] SEED    = 16'hACE1;

  // clock / reset
  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  rsg_param_seq_gen_if #(.DW(DW), .MAX_LEN(MAX_LEN), .LW(LW)) bus ();

  rsg_param_seq_gen #(.DW(DW), .MAX_LEN(MAX_LEN), .LW(LW), .SEED(SEED)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int seen_done = 0;
  int unsigned edge_cnt;
  logic [LW+DW-1:0]      exp_q[$];
  logic [MAX_LEN*DW-1:0] exp_store_q[$];
  logic [MAX_LEN*DW-1:0] last_store;

  always @(posedge clock or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: LFSR value after n clock edges from reset.
  function automatic logic [15:0] lfsr_after(input int unsigned n);
    logic [15:0] s;
    s = SEED;
    for (int unsigned k = 0; k < n; k++)
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  function automatic logic [MAX_LEN*DW-1:0] model_seq(input int unsigned first_edge, input int len);
    logic [15:0]           s;
    logic [DW-1:0]         raw, prev, d;
    logic [MAX_LEN*DW-1:0] st;
    s    = lfsr_after(first_edge);
    st   = '0;
    prev = '0;
    for (int i = 0; i < len; i++) begin
      raw = s[DW-1:0];
      d   = (i > 0 && raw == prev) ? raw + DW'(1) : raw;
      st[i*DW +: DW] = d;
      prev = d;
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    return st;
  endfunction

  task automatic push_show(input logic [MAX_LEN*DW-1:0] st, input int len);
    exp_store_q.push_back(st);
    for (int i = 0; i < len; i++)
      exp_q.push_back({LW'(i), st[i*DW +: DW]});
    exp_done++;
  endtask

  // monitor
  logic          mon_prev_valid = 1'b0;
  logic [LW-1:0] mon_prev_idx   = '0;
  always @(negedge clock) begin
    if (!rst) begin
      if (bus.flash_valid && (!mon_prev_valid || bus.flash_idx != mon_prev_idx)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flash: got idx %0d digit %0h expected none", bus.flash_idx, bus.flash_digit);
        end else begin
          check("flash_idx_digit", {bus.flash_idx, bus.flash_digit}, exp_q.pop_front());
        end
        if (!mon_prev_valid) begin
          if (exp_store_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_show: got store %0h expected none", bus.seq_store);
          end else begin
            check("store_at_show", bus.seq_store, exp_store_q.pop_front());
          end
        end
      end
      if (bus.done) seen_done++;
    end
    mon_prev_valid = bus.flash_valid;
    mon_prev_idx   = bus.flash_idx;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_valid"}, bus.flash_valid, 0);
    check({tag, "_store"}, bus.seq_store, 0);
    check({tag, "_len"},   bus.seq_len, 0);
    check({tag, "_done"},  bus.done, 0);
  endtask

  // Displays len digits; abort_at >= 0 replaces that tick with a 2-cycle reset.
  task automatic show_ticks(input int len, input int gap, input bit start_hold, input int abort_at);
    for (int k = 0; k < len; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.start = start_hold;
        if (start_hold) bus.level = LW'($urandom);
        @(negedge clock);
      end
      bus.start = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_show_rst");
        repeat (2) @(negedge clock);
        rst = 1'b0;
        exp_q.delete();
        exp_store_q.delete();
        exp_done--;
        last_store = '0;
        return;
      end
      bus.tick = 1'b1;
      @(negedge clock);
      bus.tick = 1'b0;
      if (k < len - 1) begin
        check("busy_show", bus.busy, 1);
        check("len_hold", bus.seq_len, len);
      end else begin
        check("done_pulse", bus.done, 1);
        check("busy_drop", bus.busy, 0);
        check("valid_drop", bus.flash_valid, 0);
        @(negedge clock);
        check("done_single", bus.done, 0);
      end
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_round(input logic [LW-1:0] lvl, input int auth_dly, input int gap,
                           input bit start_hold, input bit arm_ticks, input int abort_at);
    int len;
    logic [MAX_LEN*DW-1:0] st;
    len = (lvl == 0) ? 1 : ((int'(lvl) > MAX_LEN) ? MAX_LEN : int'(lvl));
    bus.level = lvl;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.level = LW'($urandom);
    check("seq_len", bus.seq_len, len);
    for (int a = 0; a < auth_dly; a++) begin
      bus.tick = arm_ticks ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
      check("arm_busy", bus.busy, 1);
      check("arm_valid", bus.flash_valid, 0);
      check("arm_store", bus.seq_store, last_store);
    end
    bus.tick = 1'b0;
    bus.auth = 1'b1;
    st = model_seq(edge_cnt + 1, len);
    push_show(st, len);
    for (int k = 0; k < len; k++) begin
      @(negedge clock);
      bus.auth = 1'($urandom_range(0, 1));
      bus.tick = 1'($urandom_range(0, 1));
    end
    check("gen_not_done", bus.flash_valid, 0);
    @(negedge clock);
    bus.tick = 1'b0;
    bus.auth = 1'b0;
    check("gen_len_show", bus.flash_valid, 1);
    for (int i = 1; i < len; i++)
      check("adjacent_distinct", bus.seq_store[i*DW +: DW] != bus.seq_store[(i-1)*DW +: DW], 1);
    last_store = st;
    show_ticks(len, gap, start_hold, abort_at);
    if (abort_at < 0) check("store_after", bus.seq_store, st);
  endtask

  logic [MAX_LEN*DW-1:0] first_store;

  initial begin
    bus.start = 1'b0;
    bus.auth  = 1'b0;
    bus.level = '0;
    bus.tick  = 1'b0;
`ifdef RSG_REPLAY_EN
    bus.replay = 1'b0;
`endif
    last_store = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    check("reset_idx", bus.flash_idx, 0);
    rst = 1'b0;
    @(negedge clock);

    // reset mid-SHOW, then an identically timed round must repeat the sequence
    first_store = model_seq(edge_cnt + 4, 3);
    run_round(3'd3, 2, 12, 1'b0, 1'b0, 1);
    @(negedge clock);
    run_round(3'd3, 2, 12, 1'b0, 1'b0, -1);
    check("repeat_after_reset", bus.seq_store, first_store);

    run_round(3'd5, 2, 12, 1'b0, 1'b0, -1);
    run_round(3'd0, 1, 3, 1'b0, 1'b0, -1);
    run_round(3'd7, 3, 4, 1'b1, 1'b0, -1);
    run_round(3'd2, 20, 5, 1'b0, 1'b1, -1);

`ifdef RSG_REPLAY_EN
    run_round(3'd4, 2, 3, 1'b0, 1'b0, -1);
    bus.replay = 1'b1;
    push_show(last_store, 4);
    @(negedge clock);
    bus.replay = 1'b0;
    check("replay_busy", bus.busy, 1);
    show_ticks(4, 2, 1'b0, -1);
    check("replay_store", bus.seq_store, last_store);
`endif

    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_round(LW'($urandom_range(0, 7)), $urandom_range(1, 6), $urandom_range(1, 8),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(negedge clock);
    check("final_queue", exp_q.size() + exp_store_q.size(), 0);
    check("done_count", seen_done, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsg_param_seq_gen.md
Name: rsg_param_seq_gen

Overview:
Parametrised random sequence generator for the memory-tester game.
- On a start pulse, once the player is authenticated, builds a pseudo-random digit sequence whose length follows the current level.
- Stores the sequence in a flat register for the answer checker.
- Flashes the digits one at a time, paced by an external interval tick from the game timer.
- Generalises the fixed 7-digit x 4-bit generator to any symbol width and depth, and adds a no-adjacent-repeat rule and explicit done/busy handshake.

Parameters:
DW, 4, bits per digit (symbol alphabet = 2^DW)
MAX_LEN, 7, maximum sequence length in digits
LW, 3, width of level input; must satisfy 2^LW-1 >= MAX_LEN
SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a round
auth  in  1  player-authenticated qualifier
level  in  LW  requested sequence length
tick  in  1  one-cycle flash-interval pulse from game timer
flash_digit  out  DW  digit currently displayed
flash_valid  out  1  flash_digit is meaningful
flash_idx  out  LW  index of displayed digit, 0-based
seq_store  out  MAX_LEN*DW  stored sequence; digit i at bits [i*DW +: DW]
seq_len  out  LW  latched effective length
busy  out  1  round in progress (ARM/GEN/SHOW)
done  out  1  one-cycle pulse at end of display

Behaviour:
- Reset (async, any time, including mid-round): all outputs 0, state IDLE, LFSR = SEED. The outputs seq_len, seq_store, flash_*, busy and done are all 0.
- LFSR: 16-bit Fibonacci, free-running every clock in all states.
  - Shift left; bit0 = b15^b13^b12^b10.
  - Raw digit = LFSR[DW-1:0] sampled before the shift.
- States:
  - IDLE: start=1 -> ARM. In the same edge, latch seq_len = clamp(level,1,MAX_LEN); level=0 gives 1 and level>MAX_LEN gives MAX_LEN. start in any other state is ignored.
  - ARM: wait while auth=0. On auth=1 -> GEN, clear seq_store to 0 and the internal write index to 0.
  - GEN: one digit written per clock at the write index.
    - If raw digit equals the previously written digit (index>0), write (raw+1) mod 2^DW instead.
    - After writing index seq_len-1 -> SHOW; GEN lasts exactly seq_len cycles.
    - Slots >= seq_len stay 0. auth is not re-checked in GEN.
  - SHOW:
    - On entry, flash_valid=1, flash_idx=0, flash_digit=seq_store[0].
    - Each tick advances flash_idx by 1 and updates flash_digit.
    - The tick seen while flash_idx=seq_len-1 sets flash_valid=0, pulses done for one cycle, and returns to IDLE.
    - A tick in the GEN->SHOW transition cycle is ignored.
- busy=1 exactly in ARM, GEN and SHOW. It drops in the cycle done pulses.
- seq_store holds its value in IDLE until the next ARM->GEN.
- level changes after the start edge have no effect on the current round.
- tick outside SHOW: no effect.

Optional Feature:
Macro RSG_REPLAY_EN.
- Defined: adds input replay (1 bit). replay=1 in IDLE with seq_len!=0 goes straight to SHOW, redisplaying seq_store unchanged. It skips ARM and GEN and leaves the LFSR path unaffected. If start and replay are both high, start wins.
- Not defined: no replay port. A sequence can be shown only once per generation.

Test Plan:
- Reset mid-SHOW (level=3): assert rst for 2 cycles -> within the same cycle busy=0, flash_valid=0, seq_store=0, seq_len=0; next start+auth produces the same sequence as the first run from reset.
- level=3, start then auth=1 two cycles later -> GEN lasts exactly 3 cycles; seq_store[27:12]=0; no adjacent equal digits; digits match a bit-exact LFSR model seeded 16'hACE1.
- level=5, then 5 ticks 12 cycles apart -> flash_idx steps 0..4, flash_digit matches seq_store slot each step; done pulses once, 1 cycle after the 5th tick; busy falls in the same cycle.
- level=0 -> seq_len=1, one digit, one tick ends round; level=7 with MAX_LEN=7 -> 7 digits; start held during SHOW -> ignored, sequence unchanged.
- auth=0 held 20 cycles after start -> stays in ARM, busy=1, flash_valid=0, seq_store unchanged; auth=1 -> GEN begins next cycle.
- RSG_REPLAY_EN: after a level=4 round, pulse replay -> same 4 digits flashed in order, seq_store bit-identical, done pulses once.
